ddr_rx_sequencer: RTL
=====================

// Module: ddr_rx_sequencer
// PURPOSE
//  Controller for the HDR-DDR RX deserializer during a controller read. Drives rx_en/rx_mode word by word:
//  preamble, 2 data bytes + parity per data word, then token + CRC5 on the CRC word.
//  Sits between the DDR CCC engine (start/abort, word budget) and the RX block. Returns bytes, done and an error code.
// PARAMETERS
//  WCNT_W       5     width of word budget / counter (max 31 data words)
//  TIMEOUT_CYC  1024  sys_clk cycles allowed per RX mode before timeout
// PORTS
//  i_sys_clk          in   1  system clock
//  i_sys_rst          in   1  asynchronous, active-low reset
//  i_start            in   1  1-cycle pulse: begin read; ignored unless IDLE
//  i_abort            in   1  level: abandon sequence, return to IDLE
//  i_words            in   WCNT_W  expected data words (0 = CRC word only), sampled on i_start
//  i_rx_mode_done     in   1  RX mode complete (level, may stay high)
//  i_rx_pre           in   1  preamble bit from RX
//  i_rx_error         in   1  RX check result, valid with rx_mode_done
//  i_rx_data          in   8  deserialized byte from RX
//  o_rx_en            out  1  RX enable
//  o_rx_mode          out  3  RX mode select
//  o_data             out  8  received byte
//  o_data_valid       out  1  1-cycle pulse per byte
//  o_word_ok          out  1  1-cycle pulse: parity of completed word passed
//  o_word_cnt         out  WCNT_W  data words accepted so far
//  o_done             out  1  1-cycle pulse: sequence finished (ok or error)
//  o_early            out  1  CRC word arrived before i_words words; held until next start
//  o_err_code         out  3  0 none,1 parity,2 token,3 crc,4 preamble,5 timeout,6 overrun; held until next start
// BEHAVIOUR
//  Reset: all outputs 0, o_rx_mode=PREAMBLE(3'b000), FSM=IDLE, counters 0.
//  Advance only on the rising edge of i_rx_mode_done (registered detect). o_rx_mode updates the cycle after that edge.
//  Latency: done-edge -> new mode is 2 cycles.
//  States (o_rx_mode in brackets):
//   IDLE: rx_en=0. i_start -> PRE1. Latch i_words. Clear counters, o_err_code, o_early. rx_en=1 from the next cycle.
//   PRE1[PREAMBLE] -> PRE2. Capture pre bit p1.
//   PRE2[PREAMBLE] -> Capture p2. {p1,p2}=10: word_cnt<i_words -> BYTE_HI, else err 6 -> ERR.
//     {p1,p2}=01 -> TOKEN. Set o_early if word_cnt<i_words. 00/11 -> err 4 -> ERR.
//   BYTE_HI[DESERIALIZING_BYTE] -> BYTE_LO. Pulse o_data_valid, o_data=i_rx_data.
//   BYTE_LO[DESERIALIZING_BYTE] -> PAR. Same pulse.
//   PAR[CHECK_PAR_VALUE]: i_rx_error -> err 1 -> ERR. Else pulse o_word_ok, word_cnt+1, -> PRE1.
//   TOKEN[CHECK_TOKEN]: i_rx_error -> err 2 -> ERR. Else -> CRC.
//   CRC[CHECK_CRC_VALUE]: i_rx_error -> err 3 -> ERR. Else -> FIN.
//   ERR[ERROR]: wait for RX error-recovery done-edge -> FIN.
//   FIN: rx_en=0, pulse o_done, -> IDLE.
//  Timeout: cycle counter cleared on every state change. At TIMEOUT_CYC-1 in any non-IDLE state: err 5 -> FIN.
//   No ERR mode on timeout: the bus is presumed dead.
//  First error wins; o_err_code is never overwritten within one sequence.
//  i_abort: highest priority. Next cycle FSM=IDLE, rx_en=0, no o_done pulse. o_err_code/o_word_cnt keep last values.
//  i_start and i_abort together: abort wins.
//  word_cnt saturates at 2^WCNT_W-1. Data pulse and done-edge in the same cycle are impossible (one edge per cycle).
//  Reset mid-sequence: immediate return to reset values.
// STRUCTURE
//  Shared package ddr_pkg: RX mode codes (PREAMBLE 000, CRC_PREAMBLE 001, DESERIALIZING_BYTE 011,
//   CHECK_TOKEN 111, CHECK_PAR_VALUE 110, CHECK_CRC_VALUE 010, ERROR 100), error codes, FSM state encoding.
//  One sub-module: ddr_seq_timeout. Loadable cycle counter with clear and expire outputs.
// TESTING
//  i_words=2, RX model sends 10,AB,CD,par ok,10,12,34,par ok,01,token ok,crc ok
//   -> 4 data pulses AB,CD,12,34; 2 word_ok; done; err 0; word_cnt 2.
//  i_words=3, target sends 1 word then CRC word -> o_early=1, err 0, word_cnt 1.
//  Second word parity fail -> mode ERROR; after its done: o_done, err 1, word_cnt 1.
//  Preamble 11 -> err 4. i_words=1 with 2 words offered -> err 6 at 2nd preamble.
//  rx_mode_done held low in BYTE_HI -> o_done at TIMEOUT_CYC, err 5, no ERROR mode issued.
//  i_abort in PAR -> rx_en=0 next cycle, no o_done. Start pulse while busy ignored. Mid-sequence reset -> all outputs 0.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared definitions for the HDR-DDR RX read sequencer: RX mode codes, error codes
// and the sequencer state encoding.
package ddr_pkg;

    typedef enum logic [2:0] {
        RX_PREAMBLE     = 3'b000,
        RX_CRC_PREAMBLE = 3'b001,
        RX_DESER_BYTE   = 3'b011,
        RX_CHECK_TOKEN  = 3'b111,
        RX_CHECK_PAR    = 3'b110,
        RX_CHECK_CRC    = 3'b010,
        RX_ERROR        = 3'b100
    } rx_mode_e;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_PARITY   = 3'd1,
        ERR_TOKEN    = 3'd2,
        ERR_CRC      = 3'd3,
        ERR_PREAMBLE = 3'd4,
        ERR_TIMEOUT  = 3'd5,
        ERR_OVERRUN  = 3'd6
    } err_code_e;

    typedef enum logic [3:0] {
        ST_IDLE, ST_PRE1, ST_PRE2, ST_BYTE_HI, ST_BYTE_LO,
        ST_PAR, ST_TOKEN, ST_CRC, ST_ERR, ST_FIN
    } seq_state_e;

    // What the RX block reports alongside a mode-done edge.
    typedef struct packed {
        logic       pre;
        logic       error;
        logic [7:0] data;
    } rx_rsp_t;

    function automatic rx_mode_e state_rx_mode(seq_state_e s);
        rx_mode_e m;
        case (s)
            ST_BYTE_HI, ST_BYTE_LO: m = RX_DESER_BYTE;
            ST_PAR:                 m = RX_CHECK_PAR;
            ST_TOKEN:               m = RX_CHECK_TOKEN;
            ST_CRC:                 m = RX_CHECK_CRC;
            ST_ERR:                 m = RX_ERROR;
            default:                m = RX_PREAMBLE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ddr_seq_timeout.sv
// Per-state watchdog: counts cycles while enabled, cleared on state change,
// flags expiry on the last allowed cycle and holds there.
module ddr_seq_timeout #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic i_sys_clk,
    input  logic i_sys_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    assign o_expire = i_en && (cnt == LIMIT);

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst)
            cnt <= '0;
        else if (i_clr)
            cnt <= '0;
        else if (i_en && !o_expire)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/ddr_rx_sequencer.sv
// Controller-read sequencer for the HDR-DDR RX deserializer: walks preamble, data
// words and the CRC word one RX mode at a time, returning bytes, done and error code.
module ddr_rx_sequencer
    import ddr_pkg::*;
#(
    parameter int WCNT_W      = 5,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [WCNT_W-1:0] i_words,
    input  logic              i_rx_mode_done,
    input  logic              i_rx_pre,
    input  logic              i_rx_error,
    input  logic [7:0]        i_rx_data,
    output logic              o_rx_en,
    output logic [2:0]        o_rx_mode,
    output logic [7:0]        o_data,
    output logic              o_data_valid,
    output logic              o_word_ok,
    output logic [WCNT_W-1:0] o_word_cnt,
    output logic              o_done,
    output logic              o_early,
    output logic [2:0]        o_err_code
);

    seq_state_e        state, state_nxt;
    logic [1:0]        done_pipe;
    rx_rsp_t           rsp_q;
    logic              done_rise;
    logic              tmo_expire;

    logic              p1_q, p1_nxt;
    logic [WCNT_W-1:0] words_q, word_cnt;
    err_code_e         err_q, err_set;
    logic              early_q, early_set;
    logic              start_acc, data_pulse, word_pulse;

    logic              rx_en_q, data_valid_q, word_ok_q, done_q;
    rx_mode_e          rx_mode_q;
    logic [7:0]        data_q;

    // RX outputs are sampled together with the done level so they only need to be
    // valid while done is high, not through the detect latency.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            done_pipe <= '0;
            rsp_q     <= '0;
        end else begin
            done_pipe <= {done_pipe[0], i_rx_mode_done};
            rsp_q     <= '{pre: i_rx_pre, error: i_rx_error, data: i_rx_data};
        end
    end

    assign done_rise = done_pipe[0] & ~done_pipe[1];

    ddr_seq_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .i_sys_clk (i_sys_clk),
        .i_sys_rst (i_sys_rst),
        .i_clr     (state_nxt != state),
        .i_en      (state != ST_IDLE),
        .o_expire  (tmo_expire)
    );

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        p1_nxt     = p1_q;
        err_set    = ERR_NONE;
        early_set  = 1'b0;
        start_acc  = 1'b0;
        data_pulse = 1'b0;
        word_pulse = 1'b0;
        case (state)
            ST_IDLE: if (i_start) begin
                state_nxt = ST_PRE1;
                start_acc = 1'b1;
            end
            ST_PRE1: if (done_rise) begin
                p1_nxt    = rsp_q.pre;
                state_nxt = ST_PRE2;
            end
            ST_PRE2: if (done_rise) begin
                case ({p1_q, rsp_q.pre})
                    2'b10: if (word_cnt < words_q) state_nxt = ST_BYTE_HI;
                           else begin err_set = ERR_OVERRUN; state_nxt = ST_ERR; end
                    2'b01: begin
                        state_nxt = ST_TOKEN;
                        early_set = (word_cnt < words_q);
                    end
                    default: begin err_set = ERR_PREAMBLE; state_nxt = ST_ERR; end
                endcase
            end
            ST_BYTE_HI: if (done_rise) begin
                data_pulse = 1'b1;
                state_nxt  = ST_BYTE_LO;
            end
            ST_BYTE_LO: if (done_rise) begin
                data_pulse = 1'b1;
                state_nxt  = ST_PAR;
            end
            ST_PAR: if (done_rise) begin
                if (rsp_q.error) begin err_set = ERR_PARITY; state_nxt = ST_ERR; end
                else begin word_pulse = 1'b1; state_nxt = ST_PRE1; end
            end
            ST_TOKEN: if (done_rise) begin
                if (rsp_q.error) begin err_set = ERR_TOKEN; state_nxt = ST_ERR; end
                else state_nxt = ST_CRC;
            end
            ST_CRC: if (done_rise) begin
                if (rsp_q.error) begin err_set = ERR_CRC; state_nxt = ST_ERR; end
                else state_nxt = ST_FIN;
            end
            ST_ERR:  if (done_rise) state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        // A dead bus gets no ERROR mode: go straight to FIN.
        if (tmo_expire && state != ST_IDLE && state != ST_FIN) begin
            state_nxt  = ST_FIN;
            err_set    = ERR_TIMEOUT;
            early_set  = 1'b0;
            data_pulse = 1'b0;
            word_pulse = 1'b0;
        end
        if (i_abort) begin
            state_nxt  = ST_IDLE;
            err_set    = ERR_NONE;
            early_set  = 1'b0;
            start_acc  = 1'b0;
            data_pulse = 1'b0;
            word_pulse = 1'b0;
        end
    end

    // Outputs are registered from the next state so the RX sees its new mode
    // two cycles after its done edge, and abort drops rx_en immediately.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            p1_q         <= 1'b0;
            words_q      <= '0;
            word_cnt     <= '0;
            err_q        <= ERR_NONE;
            early_q      <= 1'b0;
            rx_en_q      <= 1'b0;
            rx_mode_q    <= RX_PREAMBLE;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            word_ok_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            p1_q         <= p1_nxt;
            rx_en_q      <= (state_nxt != ST_IDLE) && (state_nxt != ST_FIN);
            rx_mode_q    <= state_rx_mode(state_nxt);
            data_valid_q <= data_pulse;
            word_ok_q    <= word_pulse;
            done_q       <= (state_nxt == ST_FIN);
            if (data_pulse) data_q <= rsp_q.data;
            if (start_acc) begin
                words_q  <= i_words;
                word_cnt <= '0;
                err_q    <= ERR_NONE;
                early_q  <= 1'b0;
            end else begin
                if (word_pulse && word_cnt != '1) word_cnt <= word_cnt + 1'b1;
                if (err_set != ERR_NONE && err_q == ERR_NONE) err_q <= err_set;
                if (early_set) early_q <= 1'b1;
            end
        end
    end

    assign o_rx_en      = rx_en_q;
    assign o_rx_mode    = rx_mode_q;
    assign o_data       = data_q;
    assign o_data_valid = data_valid_q;
    assign o_word_ok    = word_ok_q;
    assign o_word_cnt   = word_cnt;
    assign o_done       = done_q;
    assign o_early      = early_q;
    assign o_err_code   = err_q;

endmodule
